// File: rtl/downsample_capture.sv
// Triggered capture buffer for a decimated sample stream: arm, wait for a
// software/level/immediate trigger, store a fixed-length record, read it back.
module downsample_capture #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 16
) (
  input  logic                     sys_clk,
  input  logic                     rst_n,
  input  logic signed [DATA_W-1:0] sample_in,
  input  logic                     sample_valid,
  input  logic                     arm,
  input  logic                     abort,
  input  logic                     sw_trig,
  input  logic [1:0]               trig_mode,
  input  logic signed [DATA_W-1:0] trig_level,
  input  logic [ADDR_W:0]          capture_len,
  input  logic [ADDR_W-1:0]        rd_addr,
  output logic signed [DATA_W-1:0] rd_data,
  output logic [1:0]               state,
  output logic                     busy,
  output logic                     done,
  output logic [ADDR_W:0]          wr_count
);

  localparam logic [1:0] ST_IDLE    = 2'b00;
  localparam logic [1:0] ST_ARMED   = 2'b01;
  localparam logic [1:0] ST_CAPTURE = 2'b10;
  localparam logic [1:0] ST_DONE    = 2'b11;

  localparam int              DEPTH   = 1 << ADDR_W;
  localparam logic [ADDR_W:0] DEPTH_W = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] ONE     = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W:0] ZERO    = '0;

  logic [1:0]               state_q;
  logic [ADDR_W:0]          len_q;
  logic [ADDR_W:0]          wr_count_q;
  logic signed [DATA_W-1:0] prev_q;
  logic                     prev_valid_q;
  logic                     pend_q;
  logic signed [DATA_W-1:0] rd_data_q;
  logic signed [DATA_W-1:0] mem [DEPTH];

  logic [ADDR_W:0]   eff_len;
  logic [ADDR_W:0]   next_count;
  logic              rise_hit;
  logic              fall_hit;
  logic              trig_hit;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    eff_len = capture_len;
    if (capture_len == ZERO || capture_len > DEPTH_W) eff_len = DEPTH_W;

    // Both operands are signed, so these are two's-complement compares.
    rise_hit = prev_valid_q && (prev_q < trig_level) && (sample_in >= trig_level);
    fall_hit = prev_valid_q && (prev_q > trig_level) && (sample_in <= trig_level);

    case (trig_mode)
      2'b00:   trig_hit = 1'b0;
      2'b01:   trig_hit = rise_hit;
      2'b10:   trig_hit = fall_hit;
      default: trig_hit = 1'b1;
    endcase
    trig_hit = trig_hit | pend_q | sw_trig;

    next_count = wr_count_q + ONE;
    wr_en      = 1'b0;
    wr_addr    = wr_count_q[ADDR_W-1:0];
    if (rst_n && !abort && sample_valid) begin
      if (state_q == ST_ARMED && trig_hit) begin
        wr_en   = 1'b1;
        wr_addr = '0;
      end else if (state_q == ST_CAPTURE) begin
        wr_en = 1'b1;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // samples the pre-edge values of the others.
  always_ff @(posedge sys_clk) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      len_q        <= '0;
      wr_count_q   <= '0;
      prev_q       <= '0;
      prev_valid_q <= 1'b0;
      pend_q       <= 1'b0;
      rd_data_q    <= '0;
    end else begin
      rd_data_q <= mem[rd_addr];
      if (abort) begin
        state_q <= ST_IDLE;
        pend_q  <= 1'b0;
      end else begin
        case (state_q)
          ST_IDLE, ST_DONE: begin
            if (arm) begin
              state_q      <= ST_ARMED;
              len_q        <= eff_len;
              wr_count_q   <= '0;
              prev_valid_q <= 1'b0;
              pend_q       <= 1'b0;
            end
          end
          ST_ARMED: begin
            if (sample_valid) begin
              prev_q       <= sample_in;
              prev_valid_q <= 1'b1;
              if (trig_hit) begin
                wr_count_q <= ONE;
                pend_q     <= 1'b0;
                state_q    <= (len_q == ONE) ? ST_DONE : ST_CAPTURE;
              end
            end else if (sw_trig) begin
              pend_q <= 1'b1;
            end
          end
          ST_CAPTURE: begin
            if (sample_valid) begin
              wr_count_q <= next_count;
              if (next_count == len_q) state_q <= ST_DONE;
            end
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  // NOTE: the sample memory has no reset; its contents survive rst_n by design.
  always_ff @(posedge sys_clk) begin
    if (wr_en) mem[wr_addr] <= sample_in;
  end

  assign rd_data  = rd_data_q;
  assign state    = state_q;
  assign busy     = (state_q == ST_ARMED) || (state_q == ST_CAPTURE);
  assign done     = (state_q == ST_DONE);
  assign wr_count = wr_count_q;

endmodule

// File: tb/tb_downsample_capture.sv
// Self-checking bench for downsample_capture: trigger-scenario table plus
// hand-written sequences for length, abort, reset and read-during-write cases.
module tb_downsample_capture;

  localparam int AW = 4;
  localparam int DW = 16;

  localparam logic [1:0] S_IDLE    = 2'b00;
  localparam logic [1:0] S_ARMED   = 2'b01;
  localparam logic [1:0] S_CAPTURE = 2'b10;
  localparam logic [1:0] S_DONE    = 2'b11;

  logic                 sys_clk;
  logic                 rst_n;
  logic signed [DW-1:0] sample_in;
  logic                 sample_valid;
  logic                 arm;
  logic                 abort;
  logic                 sw_trig;
  logic [1:0]           trig_mode;
  logic signed [DW-1:0] trig_level;
  logic [AW:0]          capture_len;
  logic [AW-1:0]        rd_addr;
  logic signed [DW-1:0] rd_data;
  logic [1:0]           state;
  logic                 busy;
  logic                 done;
  logic [AW:0]          wr_count;

  downsample_capture #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .sys_clk      (sys_clk),
    .rst_n        (rst_n),
    .sample_in    (sample_in),
    .sample_valid (sample_valid),
    .arm          (arm),
    .abort        (abort),
    .sw_trig      (sw_trig),
    .trig_mode    (trig_mode),
    .trig_level   (trig_level),
    .capture_len  (capture_len),
    .rd_addr      (rd_addr),
    .rd_data      (rd_data),
    .state        (state),
    .busy         (busy),
    .done         (done),
    .wr_count     (wr_count)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  typedef struct {
    logic [1:0]           mode;
    logic signed [DW-1:0] level;
    logic [AW:0]          len;
    int                   n;
    logic signed [DW-1:0] samp [6];
    int                   trig_idx;
    int                   exp_cnt;
    logic [1:0]           exp_state;
  } vec_t;

  typedef struct {
    int                   addr;
    logic signed [DW-1:0] data;
  } exp_t;

  localparam int NV = 7;
  vec_t tbl [NV];
  exp_t sb [$];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic signed [31:0] got,
                       input logic signed [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  // Inputs change just after the falling edge; outputs are read at the falling edge.
  task automatic cyc();
    @(negedge sys_clk);
  endtask

  task automatic send(input logic signed [DW-1:0] v, input logic with_trig);
    sample_in    = v;
    sample_valid = 1'b1;
    sw_trig      = with_trig;
    cyc();
    sample_valid = 1'b0;
    sw_trig      = 1'b0;
  endtask

  task automatic arm_pulse(input logic [AW:0] len);
    capture_len = len;
    arm         = 1'b1;
    cyc();
    arm = 1'b0;
  endtask

  task automatic abort_pulse();
    abort = 1'b1;
    cyc();
    abort = 1'b0;
  endtask

  task automatic read_check(input string name, input int addr,
                            input logic signed [DW-1:0] exp);
    rd_addr = addr[AW-1:0];
    cyc();
    check($sformatf("%s mem[%0d]", name, addr), rd_data, exp);
  endtask

  task automatic drain(input string name);
    exp_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      read_check(name, e.addr, e.data);
    end
  endtask

  initial begin
    tbl[0] = '{2'b11, 16'sd0,   5'd4, 5, '{16'sd10, 16'sd20, 16'sd30, 16'sd40, 16'sd50, 16'sd0},
               0, 4, S_DONE};
    tbl[1] = '{2'b01, 16'sd100, 5'd4, 5, '{-16'sd5, 16'sd50, 16'sd99, 16'sd100, 16'sd120, 16'sd0},
               3, 2, S_CAPTURE};
    tbl[2] = '{2'b10, 16'sd0,   5'd3, 3, '{-16'sd10, 16'sd5, -16'sd1, 16'sd0, 16'sd0, 16'sd0},
               2, 1, S_CAPTURE};
    tbl[3] = '{2'b01, -16'sd3,  5'd1, 4, '{-16'sd3, -16'sd4, -16'sd2, 16'sd7, 16'sd0, 16'sd0},
               2, 1, S_DONE};
    tbl[4] = '{2'b00, 16'sd0,   5'd4, 3, '{16'sd1, 16'sd2, 16'sd3, 16'sd0, 16'sd0, 16'sd0},
               -1, 0, S_ARMED};
    tbl[5] = '{2'b10, 16'sd50,  5'd2, 3, '{16'sd60, 16'sd50, 16'sd40, 16'sd0, 16'sd0, 16'sd0},
               1, 2, S_DONE};
    tbl[6] = '{2'b01, 16'sd0,   5'd2, 3, '{-16'sd32768, 16'sd32767, -16'sd1, 16'sd0, 16'sd0, 16'sd0},
               1, 2, S_DONE};

    rst_n        = 1'b0;
    sample_in    = '0;
    sample_valid = 1'b0;
    arm          = 1'b0;
    abort        = 1'b0;
    sw_trig      = 1'b0;
    trig_mode    = 2'b00;
    trig_level   = '0;
    capture_len  = '0;
    rd_addr      = '0;
    cyc();
    cyc();
    check("reset state", state, S_IDLE);
    check("reset busy", busy, 0);
    check("reset done", done, 0);
    check("reset wr_count", wr_count, 0);
    check("reset rd_data", rd_data, 0);
    rst_n = 1'b1;
    cyc();

    // Table-driven trigger scenarios.
    for (int t = 0; t < NV; t++) begin
      abort_pulse();
      trig_mode  = tbl[t].mode;
      trig_level = tbl[t].level;
      arm_pulse(tbl[t].len);
      check($sformatf("vec%0d armed", t), state, S_ARMED);
      for (int k = 0; k < tbl[t].n; k++) begin
        send(tbl[t].samp[k], 1'b0);
        if (tbl[t].trig_idx >= 0 && k >= tbl[t].trig_idx &&
            k - tbl[t].trig_idx < tbl[t].exp_cnt)
          sb.push_back('{k - tbl[t].trig_idx, tbl[t].samp[k]});
      end
      check($sformatf("vec%0d state", t), state, tbl[t].exp_state);
      check($sformatf("vec%0d wr_count", t), wr_count, tbl[t].exp_cnt);
      drain($sformatf("vec%0d", t));
    end

    // Software trigger remembered without a valid sample.
    abort_pulse();
    trig_mode = 2'b00;
    arm_pulse(5'd4);
    sw_trig = 1'b1;
    cyc();
    sw_trig = 1'b0;
    cyc();
    cyc();
    check("pend sw before valid state", state, S_ARMED);
    send(16'sd7, 1'b0);
    sb.push_back('{0, 16'sd7});
    check("pend sw state", state, S_CAPTURE);
    check("pend sw wr_count", wr_count, 1);
    drain("pend sw");

    // Software trigger coincident with a valid sample.
    abort_pulse();
    arm_pulse(5'd4);
    send(16'sd9, 1'b1);
    sb.push_back('{0, 16'sd9});
    check("coincident sw state", state, S_CAPTURE);
    check("coincident sw wr_count", wr_count, 1);
    drain("coincident sw");

    // Software trigger in IDLE is not remembered.
    abort_pulse();
    sw_trig = 1'b1;
    cyc();
    sw_trig = 1'b0;
    arm_pulse(5'd4);
    send(16'sd5, 1'b0);
    check("idle sw ignored state", state, S_ARMED);
    check("idle sw ignored busy", busy, 1);
    check("idle sw ignored wr_count", wr_count, 0);

    // capture_len 0 means full depth.
    abort_pulse();
    trig_mode = 2'b11;
    arm_pulse(5'd0);
    for (int k = 0; k < 16; k++) begin
      send(DW'(100 + k), 1'b0);
      sb.push_back('{k, DW'(100 + k)});
    end
    send(16'sd999, 1'b0);
    check("full depth state", state, S_DONE);
    check("full depth done", done, 1);
    check("full depth busy", busy, 0);
    check("full depth wr_count", wr_count, 16);
    drain("full depth");

    // abort and arm together from DONE: abort wins, count held.
    abort = 1'b1;
    arm   = 1'b1;
    cyc();
    abort = 1'b0;
    arm   = 1'b0;
    check("abort+arm state", state, S_IDLE);
    check("abort+arm done", done, 0);
    check("abort+arm wr_count", wr_count, 16);

    // Abort after 2 of 8, with read-during-write and arm-in-CAPTURE checks.
    arm_pulse(5'd8);
    rd_addr = '0;
    send(16'sd201, 1'b0);
    check("read during write old data", rd_data, 16'sd100);
    send(16'sd202, 1'b0);
    arm_pulse(5'd2);
    check("arm in capture state", state, S_CAPTURE);
    check("arm in capture wr_count", wr_count, 2);
    abort_pulse();
    check("abort state", state, S_IDLE);
    check("abort wr_count", wr_count, 2);
    send(16'sd203, 1'b0);
    sb.push_back('{0, 16'sd201});
    sb.push_back('{1, 16'sd202});
    drain("abort");
    read_check("abort no write", 2, 16'sd102);

    // Reset mid-capture, with a valid sample present during reset.
    arm_pulse(5'd8);
    send(16'sd301, 1'b0);
    send(16'sd302, 1'b0);
    rst_n        = 1'b0;
    sample_in    = 16'sd303;
    sample_valid = 1'b1;
    cyc();
    rst_n        = 1'b1;
    sample_valid = 1'b0;
    check("mid reset state", state, S_IDLE);
    check("mid reset busy", busy, 0);
    check("mid reset wr_count", wr_count, 0);
    check("mid reset rd_data", rd_data, 0);
    read_check("mid reset", 1, 16'sd302);
    read_check("mid reset no write", 2, 16'sd102);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/downsample_capture.md
DOWNSAMPLE_CAPTURE -- requirements
Module: downsample_capture

Interface
REQ-001 Parameter: ADDR_W, default 10, log2 of capture depth; DEPTH = 2^ADDR_W samples.
REQ-002 Parameter: DATA_W, default 16, signed sample width.
REQ-003 sys_clk  in  1  single clock; all logic on its rising edge.
REQ-004 rst_n  in  1  reset, synchronous, active-low.
REQ-005 sample_in  in  DATA_W  signed two's-complement decimated sample from the downsampling filter.
REQ-006 sample_valid  in  1  one-cycle strobe qualifying sample_in (filter ce_out).
REQ-007 arm  in  1  one-cycle pulse; starts a capture sequence.
REQ-008 abort  in  1  one-cycle pulse; cancels any capture.
REQ-009 sw_trig  in  1  one-cycle pulse; software trigger.
REQ-010 trig_mode  in  2  00 software only, 01 rising level crossing, 10 falling level crossing, 11 immediate.
REQ-011 trig_level  in  DATA_W  signed crossing threshold.
REQ-012 capture_len  in  ADDR_W+1  samples to store; 0 or values above DEPTH mean DEPTH; sampled on arm.
REQ-013 rd_addr  in  ADDR_W  readout address.
REQ-014 rd_data  out  DATA_W  readout data.
REQ-015 state  out  2  00 IDLE, 01 ARMED, 10 CAPTURE, 11 DONE.
REQ-016 busy  out  1  high in ARMED or CAPTURE.
REQ-017 done  out  1  high in DONE.
REQ-018 wr_count  out  ADDR_W+1  samples stored in the current or last capture.

Function
REQ-019 IDLE: arm goes to ARMED, latches effective length, clears wr_count, clears prev-sample-valid flag and pending trigger.
REQ-020 ARMED: trigger is evaluated only on sample_valid cycles; mode 11 triggers on the first valid sample after arm.
REQ-021 Mode 01 triggers when a stored previous sample is < trig_level and current sample >= trig_level (signed compare); mode 10 triggers when previous > trig_level and current <= trig_level.
REQ-022 Crossing detection uses only samples seen while ARMED; the first valid sample after arm never triggers by crossing.
REQ-023 sw_trig in ARMED sets a pending flag in any mode; the next valid sample triggers.
REQ-024 sw_trig coincident with a valid sample triggers on that same sample.
REQ-025 Triggering sample is written to address 0 in the cycle it is valid; wr_count becomes 1; state goes to CAPTURE.
REQ-026 CAPTURE: each valid sample is written to address wr_count, then wr_count increments.
REQ-027 When wr_count reaches the latched length (including when the triggering sample completes length 1), state goes to DONE on the cycle after the final write; no further writes occur.
REQ-028 DONE: holds wr_count and memory; arm restarts per REQ-019 and clears done.
REQ-029 arm in ARMED or CAPTURE is ignored.
REQ-030 abort in any state goes to IDLE next cycle; wr_count is held; memory is not cleared.
REQ-031 abort and arm in the same cycle: abort wins.
REQ-032 sw_trig outside ARMED is ignored and not remembered.
REQ-033 Memory is single-port write, independent read; rd_data = mem[rd_addr] registered, latency 1 cycle, valid in every state.
REQ-034 A read of the address written in the same cycle returns the old contents.
REQ-035 Samples are stored unmodified, full DATA_W width; no saturation or truncation.

Reset
REQ-036 rst_n low at a sys_clk edge: state IDLE, busy 0, done 0, wr_count 0, pending trigger and prev-valid flags cleared, rd_data 0.
REQ-037 Reset mid-capture aborts the capture without further writes; memory contents are undefined after power-up and preserved across reset.

Verification
REQ-038 Mode 11, capture_len 4, arm, then valid samples 10,20,30,40,50 -> mem[0..3] = 10,20,30,40; done after 4th; wr_count 4; 50 not stored.
REQ-039 Mode 01, level 100, samples -5,50,99,100,120 after arm -> trigger on 100; mem[0] = 100, mem[1] = 120.
REQ-040 Mode 10, level 0, first sample after arm -10, then 5,-1 -> no trigger on -10; trigger on -1.
REQ-041 Mode 00, sw_trig with no valid sample, then valid 7 three cycles later -> mem[0] = 7, state CAPTURE.
REQ-042 capture_len 0 with ADDR_W 4 -> 16 samples stored, wr_count 16, then DONE.
REQ-043 Abort or rst_n low after 2 of 8 samples -> IDLE next cycle, no further writes; after abort wr_count 2; after reset wr_count 0; read mem[1] returns the 2nd sample with 1-cycle latency.
